vip_frame_scheduler: RTL
========================

# vip_frame_scheduler

Frame-level controller placed in front of the gray mean-filter video processor. It arms on a host command and forwards only whole frames from the CMOS pixel stream into the processor, so the filter never starts mid-frame. It runs a host-programmed number of frames, or runs continuously, and checks every forwarded frame against the configured geometry. Per-frame done/error status goes to the host.

## Interface
Parameters:
- IMG_HDISP, 10'd640: required active pixels per line.
- IMG_VDISP, 10'd480: required active lines per frame.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle run request; honoured only in IDLE.
- cfg_stop  in  1  one-cycle stop request.
- cfg_frames  in  8  frames to run; 0 = continuous; latched on an accepted cfg_start.
- per_frame_vsync  in  1  input frame valid; high for the whole frame.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel strobe.
- per_img_G  in  8  input gray pixel.
- proc_frame_vsync  out  1  gated vsync to the processor.
- proc_frame_href  out  1  gated href to the processor.
- proc_frame_clken  out  1  gated pixel strobe to the processor.
- proc_img_G  out  8  gated pixel; 0 when the gate is closed.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse per forwarded frame.
- frame_err  out  1  valid with frame_done; the frame's geometry mismatched.
- frame_cnt  out  8  forwarded frames since the last accepted start; wraps at 255.

## Operation
- Edge detect registers vs_d and hr_d hold the previous vsync and href.
  - vs_d resets to 1 and hr_d resets to 0, so an in-progress frame at reset release never reads as a start.
  - rise = vsync & ~vs_d; fall = ~vsync & vs_d.
- States:
  - IDLE: cfg_start & ~cfg_stop → ARM. On that transition frames_left <= cfg_frames, frame_cnt <= 0 and stop_pend <= 0.
  - ARM: cfg_stop → IDLE (stop has priority over a same-cycle rise). Otherwise rise → RUN, gate opens that cycle, pix_cnt, line_cnt and line_err clear.
  - RUN: gate open. cfg_stop sets stop_pend. fall → CHECK; the falling sample itself is still forwarded.
  - CHECK (one cycle): gate closed. Asserts frame_done next cycle with frame_err = line_err | (line_cnt != IMG_VDISP) | (hr_d at fall). frame_cnt increments.
    - Goes to IDLE if stop_pend, or if frames_left == 1.
    - Otherwise goes to ARM, and frames_left decrements when it is non-zero.
    - cfg_stop received during CHECK also counts as stop.
- Gating: while the gate is open, proc_* <= per_*. Otherwise proc_* <= 0.
- Geometry counting, RUN only:
  - pix_cnt (10 bit, saturates at 1023) increments on href & clken.
  - On href fall (hr_d & ~href): line_err |= (pix_cnt != IMG_HDISP), then line_cnt increments (saturates at 1023) and pix_cnt clears.
  - A line still open at vsync fall is a truncated line and is an error.
- Continuous mode (cfg_frames=0) runs until cfg_stop.
- A rise occurring during CHECK or IDLE is ignored. That frame is skipped whole and never partially forwarded.

## Timing
- Reset: state IDLE. All outputs 0, frame_cnt 0, frames_left 0, stop_pend 0.
- Stream latency: exactly 1 clk. Input sampled at cycle t appears on proc_* at t+1.
- Input vsync rise sampled at t while in ARM → proc_frame_vsync=1 at t+1.
- Input vsync fall sampled at t in RUN:
  - t+1: proc_frame_vsync=0 and state=CHECK.
  - t+2: frame_done=1 and state=ARM or IDLE.
- Consecutive frames are captured only when vsync low time is ≥2 clk. A 1-clk blank causes the next frame to be skipped.
- busy falls in the same cycle that frame_done pulses for the last frame. When stopped from ARM, busy falls 1 clk after cfg_stop.
- Reset mid-frame:
  - proc_* drop to 0 on the next edge and stay 0 until start, then a new rise.
  - No frame_done is generated for the aborted frame.

## Test plan
Bench uses IMG_HDISP=8, IMG_VDISP=4, and inputs of 4 lines × 8 clken pixels with ≥2 clk blanking.
- cfg_frames=2, start issued mid-frame → the in-progress frame is not forwarded. The next two frames are forwarded with 1-clk latency and bit-exact data. Two frame_done pulses with frame_err=0, frame_cnt=2, then IDLE with busy=0.
- cfg_frames=0, with cfg_stop pulsed during the 3rd frame → the 3rd frame completes fully. Third frame_done, then IDLE, frame_cnt=3.
- Line 2 carries 7 pixels → frame_done with frame_err=1. The next correct frame gives frame_err=0.
- Frame of 3 lines, and a separate frame where vsync falls while href is still high → frame_err=1 for both.
- 1-clk vsync blank between frames with cfg_frames=2 → the second frame is skipped and the third is forwarded. frame_cnt=2.
- rst asserted mid-RUN → proc_*=0 on the next edge and no frame_done. cfg_start and cfg_stop in the same IDLE cycle → state stays IDLE.

Source files
------------

// File: rtl/vip_frame_scheduler.sv
// Frame-level gate in front of the gray mean-filter: forwards only whole frames
// after a host start, counts them, and checks each forwarded frame's geometry.
module vip_frame_scheduler #(
   parameter logic [9:0] IMG_HDISP = 10'd640,
   parameter logic [9:0] IMG_VDISP = 10'd480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_start,
   input  logic       cfg_stop,
   input  logic [7:0] cfg_frames,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_G,
   output logic       proc_frame_vsync,
   output logic       proc_frame_href,
   output logic       proc_frame_clken,
   output logic [7:0] proc_img_G,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_err,
   output logic [7:0] frame_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_CHECK} state_t;

   state_t      state_q, state_d;
   logic        vs_q, hr_q;
   logic        pvs_q, pvs_d, phr_q, phr_d, pck_q, pck_d;
   logic [7:0]  pg_q, pg_d;
   logic        done_q, done_d, err_q, err_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d, frames_left_q, frames_left_d;
   logic        stop_pend_q, stop_pend_d;
   logic [9:0]  pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
   logic        line_err_q, line_err_d, trunc_q, trunc_d;
   logic        rise, fall, gate;

   assign rise = per_frame_vsync & ~vs_q;
   assign fall = ~per_frame_vsync & vs_q;

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      frames_left_d = frames_left_q;
      stop_pend_d   = stop_pend_q;
      pix_cnt_d     = pix_cnt_q;
      line_cnt_d    = line_cnt_q;
      line_err_d    = line_err_q;
      trunc_d       = trunc_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      gate          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_start && !cfg_stop) begin
               state_d       = S_ARM;
               frames_left_d = cfg_frames;
               frame_cnt_d   = '0;
               stop_pend_d   = 1'b0;
            end
         end
         S_ARM: begin
            if (cfg_stop) begin
               state_d = S_IDLE;
            end else if (rise) begin
               state_d    = S_RUN;
               gate       = 1'b1;
               pix_cnt_d  = '0;
               line_cnt_d = '0;
               line_err_d = 1'b0;
            end
         end
         S_RUN: begin
            gate = 1'b1;
            if (cfg_stop) stop_pend_d = 1'b1;
            if (hr_q && !per_frame_href) begin
               line_err_d = line_err_q | (pix_cnt_q != IMG_HDISP);
               if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;
               pix_cnt_d = '0;
            end else if (per_frame_href && per_frame_clken && pix_cnt_q != '1) begin
               pix_cnt_d = pix_cnt_q + 10'd1;
            end
            // a line still open when vsync drops is a truncated line
            if (fall) begin
               state_d = S_CHECK;
               trunc_d = hr_q;
            end
         end
         S_CHECK: begin
            done_d      = 1'b1;
            err_d       = line_err_q | (line_cnt_q != IMG_VDISP) | trunc_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (stop_pend_q || cfg_stop || frames_left_q == 8'd1) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ARM;
               if (frames_left_q != '0) frames_left_d = frames_left_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      pvs_d = gate & per_frame_vsync;
      phr_d = gate & per_frame_href;
      pck_d = gate & per_frame_clken;
      pg_d  = gate ? per_img_G : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         vs_q          <= 1'b1;
         hr_q          <= 1'b0;
         pvs_q         <= 1'b0;
         phr_q         <= 1'b0;
         pck_q         <= 1'b0;
         pg_q          <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         frame_cnt_q   <= '0;
         frames_left_q <= '0;
         stop_pend_q   <= 1'b0;
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         line_err_q    <= 1'b0;
         trunc_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         vs_q          <= per_frame_vsync;
         hr_q          <= per_frame_href;
         pvs_q         <= pvs_d;
         phr_q         <= phr_d;
         pck_q         <= pck_d;
         pg_q          <= pg_d;
         done_q        <= done_d;
         err_q         <= err_d;
         frame_cnt_q   <= frame_cnt_d;
         frames_left_q <= frames_left_d;
         stop_pend_q   <= stop_pend_d;
         pix_cnt_q     <= pix_cnt_d;
         line_cnt_q    <= line_cnt_d;
         line_err_q    <= line_err_d;
         trunc_q       <= trunc_d;
      end
   end

   assign proc_frame_vsync = pvs_q;
   assign proc_frame_href  = phr_q;
   assign proc_frame_clken = pck_q;
   assign proc_img_G       = pg_q;
   assign busy             = (state_q != S_IDLE);
   assign frame_done       = done_q;
   assign frame_err        = err_q;
   assign frame_cnt        = frame_cnt_q;

endmodule
